mem_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing the single read/write port of the on-chip 64-bit dpram64 memory.
- Requester 0 is the axi2mem bridge output; requester 1 is a secondary master (boot loader / debug DMA).
- Issues at most one memory access per cycle and returns read data to the owning requester after the fixed 1-cycle RAM latency.
- Supports bounded locked bursts.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between two requesters, the memory-port arbiter and the dpram64 RAM port.
// The slave modport is the arbiter's view; the master modport drives requests and RAM read data.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16
) ();
  logic          i_req0;
  logic          i_req1;
  logic          i_lock0;
  logic          i_lock1;
  logic          i_we0;
  logic          i_we1;
  logic [31:0]   i_addr0;
  logic [31:0]   i_addr1;
  logic [7:0]    i_be0;
  logic [7:0]    i_be1;
  logic [63:0]   i_wdata0;
  logic [63:0]   i_wdata1;
  logic          o_gnt0;
  logic          o_gnt1;
  logic          o_rvalid0;
  logic          o_rvalid1;
  logic [63:0]   o_rdata0;
  logic [63:0]   o_rdata1;
  logic [7:0]    o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [63:0]   o_mem_wdata;
  logic [63:0]   i_mem_rdata;

  modport slave (
    input  i_req0, i_req1, i_lock0, i_lock1, i_we0, i_we1, i_addr0, i_addr1,
    input  i_be0, i_be1, i_wdata0, i_wdata1, i_mem_rdata,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
    output o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req0, i_req1, i_lock0, i_lock1, i_we0, i_we1, i_addr0, i_addr1,
    output i_be0, i_be1, i_wdata0, i_wdata1, i_mem_rdata,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
    input  o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the single dpram64 port, with bounded locked bursts
// and 1-cycle read-data return to the requester that issued the read.
module mem_port_arbiter #(
  parameter int unsigned MEM_SIZE = 65536,
  parameter int unsigned MAX_LOCK = 16
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned AW   = $clog2(MEM_SIZE);
  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
  typedef logic [CntW-1:0] cnt_t;

  logic [1:0] req, lock, we;
  assign req  = {bus.i_req1, bus.i_req0};
  assign lock = {bus.i_lock1, bus.i_lock0};
  assign we   = {bus.i_we1, bus.i_we0};

  logic prio_q, prio_d;
  logic own_vld_q, own_vld_d;
  logic own_id_q, own_id_d;
  cnt_t lock_cnt_q, lock_cnt_d;
  logic rpend_q, rpend_d;
  logic rsel_q, rsel_d;

  logic own_live, gnt_vld, gnt_id, other_req;
  cnt_t cnt_base, cnt_inc;

  always_comb begin
    own_live = own_vld_q & req[own_id_q];
    gnt_vld  = rst_n & (|req);
    if (own_live) begin
      gnt_id = own_id_q;
    end else if (&req) begin
      gnt_id = prio_q;
    end else begin
      gnt_id = req[1];
    end
  end

  always_comb begin
    prio_d     = prio_q;
    own_vld_d  = own_live;
    own_id_d   = own_id_q;
    cnt_base   = own_live ? lock_cnt_q : '0;
    cnt_inc    = cnt_base + cnt_t'(1);
    lock_cnt_d = cnt_base;
    other_req  = req[~gnt_id];
    rpend_d    = gnt_vld & ~we[gnt_id];
    rsel_d     = gnt_id;
    if (gnt_vld) begin
      if (!own_live) begin
        prio_d = ~gnt_id;
      end
      if (!lock[gnt_id]) begin
        own_vld_d  = 1'b0;
        lock_cnt_d = '0;
      end else if (other_req) begin
        if (cnt_inc == cnt_t'(MAX_LOCK)) begin
          own_vld_d  = 1'b0;
          lock_cnt_d = '0;
          prio_d     = ~gnt_id;
        end else begin
          own_vld_d  = 1'b1;
          own_id_d   = gnt_id;
          lock_cnt_d = cnt_inc;
        end
      end
      // A lock request with the other side idle leaves ownership and count untouched.
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      own_vld_q  <= 1'b0;
      own_id_q   <= 1'b0;
      lock_cnt_q <= '0;
      rpend_q    <= 1'b0;
      rsel_q     <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      own_vld_q  <= own_vld_d;
      own_id_q   <= own_id_d;
      lock_cnt_q <= lock_cnt_d;
      rpend_q    <= rpend_d;
      rsel_q     <= rsel_d;
    end
  end

  logic [31:0] g_addr;
  logic [7:0]  g_be;
  logic [63:0] g_wdata;
  logic        g_we;
  logic        unused_addr;
  logic        rvalid;

  assign g_addr      = gnt_id ? bus.i_addr1 : bus.i_addr0;
  assign g_be        = gnt_id ? bus.i_be1 : bus.i_be0;
  assign g_wdata     = gnt_id ? bus.i_wdata1 : bus.i_wdata0;
  assign g_we        = we[gnt_id];
  assign unused_addr = ^g_addr;

  assign bus.o_gnt0      = gnt_vld & ~gnt_id;
  assign bus.o_gnt1      = gnt_vld & gnt_id;
  assign bus.o_mem_we    = gnt_vld ? ({8{g_we}} & g_be) : 8'h00;
  assign bus.o_mem_addr  = gnt_vld ? (g_addr[AW-1:0] & ~(AW'(7))) : '0;
  assign bus.o_mem_wdata = gnt_vld ? g_wdata : 64'h0;

  // Masking with rst_n kills a read return when reset lands in the return cycle.
  assign rvalid        = rpend_q & rst_n;
  assign bus.o_rvalid0 = rvalid & ~rsel_q;
  assign bus.o_rvalid1 = rvalid & rsel_q;
  assign bus.o_rdata0  = bus.o_rvalid0 ? bus.i_mem_rdata : 64'h0;
  assign bus.o_rdata1  = bus.o_rvalid1 ? bus.i_mem_rdata : 64'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a behavioural RAM and a
// rule-level reference model of grants, bursts and read return.
module tb_mem_port_arbiter;
  localparam int unsigned MemSize = 65536;
  localparam int unsigned MaxLock = 4;
  localparam int unsigned Aw      = 16;
  localparam int unsigned Words   = MemSize / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(Aw)) bus ();

  mem_port_arbiter #(
    .MEM_SIZE(MemSize),
    .MAX_LOCK(MaxLock)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural RAM: byte-masked write, registered read.
  logic [63:0] ram [Words];
  logic [12:0] ram_idx;
  logic [63:0] ram_w;
  bit          ram_ready = 1'b0;

  always_comb begin
    ram_idx = bus.o_mem_addr[Aw-1:3];
    ram_w   = ram[ram_idx];
    for (int b = 0; b < 8; b++) begin
      if (bus.o_mem_we[b]) ram_w[8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < Words; i++) ram[i] <= 64'h0;
      ram[0]          <= 64'h1111_2222_3333_4444;
      ram[1]          <= 64'hAAAA_BBBB_CCCC_DDDD;
      bus.i_mem_rdata <= 64'h0;
      ram_ready       <= 1'b1;
    end else begin
      ram[ram_idx]    <= ram_w;
      bus.i_mem_rdata <= ram[ram_idx];
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  bit          req_v [2];
  bit          lock_v[2];
  bit          we_v  [2];
  logic [31:0] addr_v[2];
  logic [7:0]  be_v  [2];
  logic [63:0] wd_v  [2];

  // Reference model state: favoured requester, burst owner (-1 = none), beats in burst.
  logic [63:0] shadow [Words];
  int          m_prio  = 0;
  int          m_owner = -1;
  int          m_beats = 0;
  bit          m_pend  = 1'b0;
  int          m_rsel  = 0;
  logic [63:0] m_rdata = 64'h0;
  int          g       = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.i_req0   = req_v[0];
    bus.i_req1   = req_v[1];
    bus.i_lock0  = lock_v[0];
    bus.i_lock1  = lock_v[1];
    bus.i_we0    = we_v[0];
    bus.i_we1    = we_v[1];
    bus.i_addr0  = addr_v[0];
    bus.i_addr1  = addr_v[1];
    bus.i_be0    = be_v[0];
    bus.i_be1    = be_v[1];
    bus.i_wdata0 = wd_v[0];
    bus.i_wdata1 = wd_v[1];
  endtask

  task automatic set_req(input int r, input bit rq, input bit lk, input bit w,
                         input logic [31:0] a, input logic [7:0] be, input logic [63:0] d);
    req_v[r]  = rq;
    lock_v[r] = lk;
    we_v[r]   = w;
    addr_v[r] = a;
    be_v[r]   = be;
    wd_v[r]   = d;
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance the model.
  task automatic step();
    bit          live;
    bit          rv0, rv1;
    int          o;
    logic [7:0]  e_we;
    logic [15:0] e_addr;
    logic [63:0] e_wd;
    logic [12:0] w;
    drive();
    #1;
    live = (m_owner >= 0) && req_v[m_owner];
    g    = -1;
    if (rst_n) begin
      if (live) g = m_owner;
      else if (req_v[0] && req_v[1]) g = m_prio;
      else if (req_v[0]) g = 0;
      else if (req_v[1]) g = 1;
    end
    e_we   = 8'h00;
    e_addr = 16'h0;
    e_wd   = 64'h0;
    if (g >= 0) begin
      e_addr = addr_v[g][15:0] & 16'hFFF8;
      e_we   = we_v[g] ? be_v[g] : 8'h00;
      e_wd   = wd_v[g];
    end
    rv0 = m_pend && rst_n && (m_rsel == 0);
    rv1 = m_pend && rst_n && (m_rsel == 1);
    chk("gnt0", 64'(bus.o_gnt0), 64'(g == 0));
    chk("gnt1", 64'(bus.o_gnt1), 64'(g == 1));
    chk("mem_we", 64'(bus.o_mem_we), 64'(e_we));
    chk("mem_addr", 64'(bus.o_mem_addr), 64'(e_addr));
    chk("mem_wdata", bus.o_mem_wdata, e_wd);
    chk("rvalid0", 64'(bus.o_rvalid0), 64'(rv0));
    chk("rvalid1", 64'(bus.o_rvalid1), 64'(rv1));
    chk("rdata0", bus.o_rdata0, rv0 ? m_rdata : 64'h0);
    chk("rdata1", bus.o_rdata1, rv1 ? m_rdata : 64'h0);
    @(posedge clk);
    if (!rst_n) begin
      m_prio  = 0;
      m_owner = -1;
      m_beats = 0;
      m_pend  = 1'b0;
    end else begin
      m_pend = 1'b0;
      if (!live) begin
        m_owner = -1;
        m_beats = 0;
      end
      if (g >= 0) begin
        o = 1 - g;
        if (!live) m_prio = o;
        if (!lock_v[g]) begin
          m_owner = -1;
          m_beats = 0;
        end else if (req_v[o]) begin
          m_owner = g;
          m_beats = m_beats + 1;
          if (m_beats == MaxLock) begin
            m_owner = -1;
            m_beats = 0;
            m_prio  = o;
          end
        end
        w = addr_v[g][15:3];
        if (we_v[g]) begin
          for (int b = 0; b < 8; b++) begin
            if (be_v[g][b]) shadow[w][8*b +: 8] = wd_v[g][8*b +: 8];
          end
        end else begin
          m_pend  = 1'b1;
          m_rsel  = g;
          m_rdata = shadow[w];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_req(input int r);
    logic [31:0] hi;
    hi = $urandom();
    req_v[r]  = ($urandom_range(0, 3) != 0);
    lock_v[r] = ($urandom_range(0, 2) != 0);
    we_v[r]   = ($urandom_range(0, 2) == 0);
    addr_v[r] = (hi & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 3)
              | 32'($urandom_range(0, 7));
    be_v[r]   = 8'($urandom());
    wd_v[r]   = {$urandom(), $urandom()};
  endtask

  initial begin
    for (int i = 0; i < Words; i++) shadow[i] = 64'h0;
    shadow[0] = 64'h1111_2222_3333_4444;
    shadow[1] = 64'hAAAA_BBBB_CCCC_DDDD;

    // Reset held 3 cycles with both requesting.
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 8'hFF, 64'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 8'hFF, 64'h0);
    repeat (3) step();
    rst_n = 1'b1;

    // Round-robin reads; the first cycle out of reset must favour requester 0.
    drive();
    #1;
    chk("post_reset_gnt0", 64'(bus.o_gnt0), 64'h1);
    repeat (6) step();

    // Write from requester 0 with partial byte enables, then read back by requester 1.
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 8'h0F, 64'hDEAD_BEEF_0123_4567);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 8'h00, 64'h0);
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
    drive();
    #1;
    chk("wr_rd_rdata1", bus.o_rdata1, 64'h0000_0000_0123_4567);
    step();

    // Locked burst from requester 0 capped at MaxLock beats.
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 8'h00, 64'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 8'h00, 64'h0);
    for (int c = 0; c < 8; c++) begin
      if (c == 4) begin
        drive();
        #1;
        chk("lock_handover_gnt1", 64'(bus.o_gnt1), 64'h1);
      end
      step();
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    step();
    req_v[1] = 1'b1;
    step();

    // Lock dropped on the third beat: requester 1 wins the following cycle.
    req_v[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      lock_v[0] = (c < 2);
      if (c == 3) begin
        drive();
        #1;
        chk("early_release_gnt1", 64'(bus.o_gnt1), 64'h1);
      end
      step();
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    step();

    // Unaligned address above MEM_SIZE wraps and aligns.
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0001_000D, 8'h00, 64'h0);
    drive();
    #1;
    chk("wrap_addr", 64'(bus.o_mem_addr), 64'h0008);
    step();

    // Reset in the cycle after a read grant suppresses its return and resets priority.
    req_v[0] = 1'b0;
    rst_n    = 1'b0;
    drive();
    #1;
    chk("midop_no_rvalid0", 64'(bus.o_rvalid0), 64'h0);
    step();
    rst_n    = 1'b1;
    req_v[0] = 1'b1;
    req_v[1] = 1'b1;
    drive();
    #1;
    chk("midop_prio_gnt0", 64'(bus.o_gnt0), 64'h1);
    step();

    // Randomized traffic: requests held until granted, occasionally withdrawn.
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (g == r || !req_v[r]) rand_req(r);
        else if ($urandom_range(0, 7) == 0) req_v[r] = 1'b0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
